// File: rtl/uart_ctrl_pkg.sv
// Shared command codes, FSM encodings and checksum helper for the UART frame controller.
// Checksum support is enabled with the UART_CTRL_CHKSUM_EN macro.
package uart_ctrl_pkg;

    localparam logic [7:0] CmdRun   = 8'h52;
    localparam logic [7:0] CmdStop  = 8'h93;
    localparam logic [7:0] CmdReadA = 8'h61;
    localparam logic [7:0] CmdReadM = 8'h6D;

    typedef enum logic [1:0] {TxIdle, TxSend, TxWait} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxArg, RxChk} rx_state_e;

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_ctrl_rx_parser.sv
// RX command parser: command filtering against core state, argument assembly, inter-byte timeout.
// With UART_CTRL_CHKSUM_EN defined, a trailing XOR byte is verified after each accepted command.
module uart_ctrl_rx_parser
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned ARG_BYTES   = 1,
    parameter int unsigned TIMEOUT_CYC = 250000,
    parameter logic [7:0]  CMD_RUN     = CmdRun,
    parameter logic [7:0]  CMD_STOP    = CmdStop,
    parameter logic [7:0]  CMD_READ_A  = CmdReadA,
    parameter logic [7:0]  CMD_READ_M  = CmdReadM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_byte,
    input  logic                        rx_byte_valid,
    input  logic                        core_busy,
    output logic [8*(1+ARG_BYTES)-1:0]  rx_data,
    output logic                        rx_valid,
    output logic                        rx_err
);

    localparam int unsigned ArgW = 8 * ARG_BYTES;
    localparam int unsigned CntW = $clog2(ARG_BYTES + 1);
    localparam int unsigned TmrW = $clog2(TIMEOUT_CYC);

    rx_state_e             state_q, state_d;
    logic [TmrW-1:0]       timer_q, timer_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [ArgW-1:0]       args_q, args_d;
    logic [7:0]            sum_q, sum_d;
    logic [ArgW+7:0]       data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  take_simple, take_read;

    // Core state decides which commands are legal at the moment the command byte lands.
    assign take_simple = core_busy ? (rx_byte == CMD_STOP) : (rx_byte == CMD_RUN);
    assign take_read   = !core_busy && (rx_byte == CMD_READ_A || rx_byte == CMD_READ_M);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        args_d  = args_q;
        sum_d   = sum_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            RxIdle: begin
                timer_d = '0;
                if (rx_byte_valid && (take_simple || take_read)) begin
                    cmd_d  = rx_byte;
                    args_d = '0;
                    cnt_d  = '0;
                    sum_d  = rx_byte;
                    if (take_read) begin
                        state_d = RxArg;
                    end else begin
`ifdef UART_CTRL_CHKSUM_EN
                        state_d = RxChk;
`else
                        valid_d = 1'b1;
                        data_d  = {rx_byte, ArgW'(0)};
`endif
                    end
                end
            end
            RxArg, RxChk: begin
                if (rx_byte_valid) begin
                    timer_d = '0;
                    if (state_q == RxArg) begin
                        args_d = ArgW'({args_q, rx_byte});
                        sum_d  = xor_fold(sum_q, rx_byte);
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CntW'(ARG_BYTES - 1)) begin
`ifdef UART_CTRL_CHKSUM_EN
                            state_d = RxChk;
`else
                            state_d = RxIdle;
                            valid_d = 1'b1;
                            data_d  = {cmd_q, ArgW'({args_q, rx_byte})};
`endif
                        end
                    end else begin
                        state_d = RxIdle;
                        if (rx_byte == sum_q) begin
                            valid_d = 1'b1;
                            data_d  = {cmd_q, args_q};
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (timer_q == TmrW'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = RxIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RxIdle;
            timer_q <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            args_q  <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            args_q  <= args_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;

endmodule

// File: rtl/uart_frame_controller.sv
// Byte-framing controller between core logic and the uart_tx/uart_rx byte engines.
// Define UART_CTRL_CHKSUM_EN to append/verify an XOR checksum byte on both paths.
module uart_frame_controller
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned MAX_BYTES   = 7,
    parameter int unsigned ARG_BYTES   = 1,
    parameter int unsigned TIMEOUT_CYC = 250000,
    parameter logic [7:0]  CMD_RUN     = CmdRun,
    parameter logic [7:0]  CMD_STOP    = CmdStop,
    parameter logic [7:0]  CMD_READ_A  = CmdReadA,
    parameter logic [7:0]  CMD_READ_M  = CmdReadM
) (
    input  logic                          i_CLK,
    input  logic                          w_rst,
    input  logic [8*MAX_BYTES-1:0]        i_TX_DATA,
    input  logic [$clog2(MAX_BYTES+1)-1:0] i_TX_LEN,
    input  logic                          i_TX_VALID,
    output logic                          o_TX_READY,
    output logic                          o_TX_FRAME_DONE,
    output logic [7:0]                    o_TX_BYTE,
    output logic                          o_TX_BYTE_VALID,
    input  logic                          i_TX_BYTE_DONE,
    input  logic [7:0]                    i_RX_BYTE,
    input  logic                          i_RX_BYTE_VALID,
    input  logic                          i_CORE_BUSY,
    output logic [8*(1+ARG_BYTES)-1:0]    o_RX_DATA,
    output logic                          o_RX_VALID,
    output logic                          o_RX_ERR
);

    localparam int unsigned DataW = 8 * MAX_BYTES;
    localparam int unsigned LenW  = $clog2(MAX_BYTES + 1);

    tx_state_e         state_q, state_d;
    logic [DataW-1:0]  shift_q, shift_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [LenW-1:0]   count_q, count_d;
    logic [7:0]        sum_q, sum_d;
    logic              sum_phase_q, sum_phase_d;
    logic              alive_q;
    logic              ready;
    logic [LenW-1:0]   len_eff;

    // Widened compare keeps the clamp meaningful even when MAX_BYTES fills the length field.
    assign len_eff = ({1'b0, i_TX_LEN} > (LenW + 1)'(MAX_BYTES)) ? LenW'(MAX_BYTES) : i_TX_LEN;
    assign ready   = (state_q == TxIdle) && alive_q;
    assign o_TX_READY = ready;
    assign o_TX_BYTE  = shift_q[DataW-1 -: 8];

    always_comb begin
        state_d         = state_q;
        shift_d         = shift_q;
        len_d           = len_q;
        count_d         = count_q;
        sum_d           = sum_q;
        sum_phase_d     = sum_phase_q;
        o_TX_BYTE_VALID = 1'b0;
        o_TX_FRAME_DONE = 1'b0;
        unique case (state_q)
            TxIdle: begin
                if (i_TX_VALID && ready && (i_TX_LEN != '0)) begin
                    shift_d     = i_TX_DATA;
                    len_d       = len_eff;
                    count_d     = '0;
                    sum_d       = '0;
                    sum_phase_d = 1'b0;
                    state_d     = TxSend;
                end
            end
            TxSend: begin
                o_TX_BYTE_VALID = 1'b1;
                if (!sum_phase_q) begin
                    count_d = count_q + 1'b1;
                    sum_d   = xor_fold(sum_q, shift_q[DataW-1 -: 8]);
                end
                state_d = TxWait;
            end
            TxWait: begin
                if (i_TX_BYTE_DONE) begin
                    if (count_q < len_q) begin
                        shift_d = shift_q << 8;
                        state_d = TxSend;
                    end else begin
`ifdef UART_CTRL_CHKSUM_EN
                        if (!sum_phase_q) begin
                            shift_d[DataW-1 -: 8] = sum_q;
                            sum_phase_d           = 1'b1;
                            state_d               = TxSend;
                        end else begin
                            o_TX_FRAME_DONE = 1'b1;
                            state_d         = TxIdle;
                        end
`else
                        o_TX_FRAME_DONE = 1'b1;
                        state_d         = TxIdle;
`endif
                    end
                end
            end
            default: state_d = TxIdle;
        endcase
    end

    always_ff @(posedge i_CLK or posedge w_rst) begin
        if (w_rst) begin
            state_q     <= TxIdle;
            shift_q     <= '0;
            len_q       <= '0;
            count_q     <= '0;
            sum_q       <= '0;
            sum_phase_q <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            sum_phase_q <= sum_phase_d;
            alive_q     <= 1'b1;
        end
    end

    uart_ctrl_rx_parser #(
        .ARG_BYTES   (ARG_BYTES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CMD_RUN     (CMD_RUN),
        .CMD_STOP    (CMD_STOP),
        .CMD_READ_A  (CMD_READ_A),
        .CMD_READ_M  (CMD_READ_M)
    ) u_rx_parser (
        .clk           (i_CLK),
        .rst           (w_rst),
        .rx_byte       (i_RX_BYTE),
        .rx_byte_valid (i_RX_BYTE_VALID),
        .core_busy     (i_CORE_BUSY),
        .rx_data       (o_RX_DATA),
        .rx_valid      (o_RX_VALID),
        .rx_err        (o_RX_ERR)
    );

endmodule

// File: tb/tb_uart_frame_controller.sv
// Self-checking bench for uart_frame_controller: vector tables plus scoreboards for both paths.
// Honours UART_CTRL_CHKSUM_EN when the design is built with it.
module tb_uart_frame_controller;

    localparam int unsigned MaxBytes   = 7;
    localparam int unsigned ArgBytes   = 1;
    localparam int unsigned TimeoutCyc = 100;
    localparam int unsigned LenW       = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [55:0] i_TX_DATA = '0;
    logic [2:0]  i_TX_LEN = '0;
    logic        i_TX_VALID = 1'b0;
    logic        o_TX_READY, o_TX_FRAME_DONE, o_TX_BYTE_VALID;
    logic [7:0]  o_TX_BYTE;
    logic        i_TX_BYTE_DONE = 1'b0;
    logic [7:0]  i_RX_BYTE = '0;
    logic        i_RX_BYTE_VALID = 1'b0;
    logic        i_CORE_BUSY = 1'b0;
    logic [15:0] o_RX_DATA;
    logic        o_RX_VALID, o_RX_ERR;

    always #5 clk = ~clk;

    uart_frame_controller #(
        .MAX_BYTES   (MaxBytes),
        .ARG_BYTES   (ArgBytes),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .i_CLK           (clk),
        .w_rst           (rst),
        .i_TX_DATA       (i_TX_DATA),
        .i_TX_LEN        (i_TX_LEN),
        .i_TX_VALID      (i_TX_VALID),
        .o_TX_READY      (o_TX_READY),
        .o_TX_FRAME_DONE (o_TX_FRAME_DONE),
        .o_TX_BYTE       (o_TX_BYTE),
        .o_TX_BYTE_VALID (o_TX_BYTE_VALID),
        .i_TX_BYTE_DONE  (i_TX_BYTE_DONE),
        .i_RX_BYTE       (i_RX_BYTE),
        .i_RX_BYTE_VALID (i_RX_BYTE_VALID),
        .i_CORE_BUSY     (i_CORE_BUSY),
        .o_RX_DATA       (o_RX_DATA),
        .o_RX_VALID      (o_RX_VALID),
        .o_RX_ERR        (o_RX_ERR)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  tx_exp[$];
    logic [15:0] rx_exp[$];
    int frame_done_cnt = 0;
    int rx_valid_cnt = 0;
    int rx_err_cnt = 0;
    int pend = 0;
    logic [15:0] last_rx = '0;

    typedef struct {
        logic [55:0] data;
        int          len;
    } tx_vec_t;

    typedef struct {
        logic        busy;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        ok;
        logic [15:0] exp;
    } rx_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor plus a uart_tx model that answers each byte 20 cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (o_TX_BYTE_VALID) begin
                    pend = 20;
                    if (tx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_unexpected_byte: got %0h, expected none", o_TX_BYTE);
                    end else begin
                        check("tx_byte", 32'(o_TX_BYTE), 32'(tx_exp.pop_front()));
                    end
                end
                if (o_TX_FRAME_DONE) frame_done_cnt++;
                if (o_RX_VALID) begin
                    rx_valid_cnt++;
                    if (rx_exp.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_unexpected_valid: got %0h, expected none", o_RX_DATA);
                    end else begin
                        check("rx_data", 32'(o_RX_DATA), 32'(rx_exp.pop_front()));
                    end
                end
                if (o_RX_ERR) rx_err_cnt++;
            end
            @(posedge clk);
            #1;
            i_TX_BYTE_DONE = 1'b0;
            if (rst) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) i_TX_BYTE_DONE = 1'b1;
            end
        end
    end

    task automatic offer_frame(input logic [55:0] data, input int len);
        int guard = 0;
        int n;
        logic [7:0] b;
`ifdef UART_CTRL_CHKSUM_EN
        logic [7:0] sum = '0;
`endif
        while (!o_TX_READY && guard < 1000) begin
            tick();
            guard++;
        end
        check("tx_ready_before_offer", 32'(o_TX_READY), 32'd1);
        n = (len > int'(MaxBytes)) ? int'(MaxBytes) : len;
        for (int i = 0; i < n; i++) begin
            b = data[55-8*i -: 8];
            tx_exp.push_back(b);
`ifdef UART_CTRL_CHKSUM_EN
            sum = sum ^ b;
`endif
        end
`ifdef UART_CTRL_CHKSUM_EN
        if (n > 0) tx_exp.push_back(sum);
`endif
        i_TX_DATA  = data;
        i_TX_LEN   = LenW'(len);
        i_TX_VALID = 1'b1;
        tick();
        i_TX_VALID = 1'b0;
        check("tx_ready_after_accept", 32'(o_TX_READY), (len == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic send_frame(input logic [55:0] data, input int len);
        int fd0 = frame_done_cnt;
        int guard = 0;
        offer_frame(data, len);
        if (len == 0) begin
            repeat (40) tick();
            check("tx_len0_no_done", 32'(frame_done_cnt), 32'(fd0));
        end else begin
            while (frame_done_cnt == fd0 && guard < 600) begin
                tick();
                guard++;
            end
            check("tx_ready_after_done", 32'(o_TX_READY), 32'd1);
            tick();
            check("tx_frame_done_once", 32'(frame_done_cnt), 32'(fd0 + 1));
        end
        check("tx_queue_drained", 32'(tx_exp.size()), 32'd0);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic busy);
        i_CORE_BUSY     = busy;
        i_RX_BYTE       = b;
        i_RX_BYTE_VALID = 1'b1;
        tick();
        i_RX_BYTE_VALID = 1'b0;
    endtask

    task automatic rx_cmd(input logic [7:0] c, input logic [7:0] a, input logic with_arg,
                          input logic [15:0] exp);
        int v0 = rx_valid_cnt;
        rx_exp.push_back(exp);
        last_rx = exp;
        rx_send(c, 1'b0);
        if (with_arg) rx_send(a, 1'b0);
`ifdef UART_CTRL_CHKSUM_EN
        rx_send(with_arg ? (c ^ a) : c, 1'b0);
`endif
        repeat (3) tick();
        check("rx_cmd_valid", 32'(rx_valid_cnt - v0), 32'd1);
    endtask

    tx_vec_t txv[5];
    rx_vec_t rxv[9];

    initial begin
        int v0, e0, fd0;
`ifdef UART_CTRL_CHKSUM_EN
        logic [7:0] rsum;
`endif
        txv[0] = '{56'h611234_00000000, 3};
        txv[1] = '{56'hAA010203040506, 7};
        txv[2] = '{56'h11223344556677, 0};
        txv[3] = '{56'h5A000000000000, 1};
        txv[4] = '{56'hFFEEDDCCBBAA99, 6};

        rxv[0] = '{1'b0, 2, 8'h6D, 8'h2A, 1'b1, 16'h6D2A};
        rxv[1] = '{1'b1, 1, 8'h52, 8'h00, 1'b0, 16'h0000};
        rxv[2] = '{1'b1, 1, 8'h93, 8'h00, 1'b1, 16'h9300};
        rxv[3] = '{1'b0, 1, 8'h52, 8'h00, 1'b1, 16'h5200};
        rxv[4] = '{1'b0, 1, 8'h93, 8'h00, 1'b0, 16'h0000};
        rxv[5] = '{1'b0, 2, 8'h61, 8'hFF, 1'b1, 16'h61FF};
        rxv[6] = '{1'b0, 1, 8'h13, 8'h00, 1'b0, 16'h0000};
        rxv[7] = '{1'b1, 1, 8'h61, 8'h00, 1'b0, 16'h0000};
        rxv[8] = '{1'b0, 2, 8'h61, 8'h52, 1'b1, 16'h6152};

        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(o_TX_READY), 32'd0);
        check("rst_tx_byte_valid", 32'(o_TX_BYTE_VALID), 32'd0);
        check("rst_tx_byte", 32'(o_TX_BYTE), 32'd0);
        check("rst_rx_data", 32'(o_RX_DATA), 32'd0);
        check("rst_rx_pulses", 32'({o_RX_VALID, o_RX_ERR, o_TX_FRAME_DONE}), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_low_at_release", 32'(o_TX_READY), 32'd0);
        tick();
        check("ready_first_cycle", 32'(o_TX_READY), 32'd1);

        for (int i = 0; i < 5; i++) send_frame(txv[i].data, txv[i].len);

        for (int i = 0; i < 9; i++) begin
            v0 = rx_valid_cnt;
            e0 = rx_err_cnt;
            if (rxv[i].ok) begin
                rx_exp.push_back(rxv[i].exp);
                last_rx = rxv[i].exp;
            end
            rx_send(rxv[i].b0, rxv[i].busy);
            if (rxv[i].n > 1) rx_send(rxv[i].b1, rxv[i].busy);
`ifdef UART_CTRL_CHKSUM_EN
            rsum = (rxv[i].n > 1) ? (rxv[i].b0 ^ rxv[i].b1) : rxv[i].b0;
            if (rxv[i].ok) rx_send(rsum, rxv[i].busy);
`endif
            check("rx_valid_latency", 32'(o_RX_VALID), 32'(rxv[i].ok));
            repeat (3) tick();
            check("rx_valid_count", 32'(rx_valid_cnt - v0), 32'(rxv[i].ok));
            check("rx_no_err", 32'(rx_err_cnt - e0), 32'd0);
            check("rx_data_hold", 32'(o_RX_DATA), 32'(last_rx));
        end

        // Timeout: exactly TimeoutCyc silent cycles after the command byte.
        v0 = rx_valid_cnt;
        e0 = rx_err_cnt;
        rx_send(8'h61, 1'b0);
        repeat (TimeoutCyc - 1) tick();
        check("rx_err_not_early", 32'(o_RX_ERR), 32'd0);
        tick();
        check("rx_err_at_timeout", 32'(o_RX_ERR), 32'd1);
        repeat (TimeoutCyc + 20) tick();
        check("rx_err_once", 32'(rx_err_cnt - e0), 32'd1);
        check("rx_no_valid_on_timeout", 32'(rx_valid_cnt - v0), 32'd0);
        check("rx_data_kept_on_timeout", 32'(o_RX_DATA), 32'(last_rx));
        rx_cmd(8'h52, 8'h00, 1'b0, 16'h5200);

        // Argument arriving just inside the window is still accepted.
        e0 = rx_err_cnt;
        rx_exp.push_back(16'h6105);
        last_rx = 16'h6105;
        v0 = rx_valid_cnt;
        rx_send(8'h61, 1'b0);
        repeat (TimeoutCyc - 10) tick();
        rx_send(8'h05, 1'b0);
`ifdef UART_CTRL_CHKSUM_EN
        rx_send(8'h64, 1'b0);
`endif
        repeat (3) tick();
        check("rx_late_arg_valid", 32'(rx_valid_cnt - v0), 32'd1);
        check("rx_late_arg_no_err", 32'(rx_err_cnt - e0), 32'd0);

        // Full duplex: a 7-byte frame with an RX command in flight.
        fork
            send_frame(56'hAA010203040506, 7);
            begin
                repeat (30) tick();
                rx_cmd(8'h61, 8'h05, 1'b1, 16'h6105);
            end
        join

        // Reset mid-frame with RX also mid-command.
        fd0 = frame_done_cnt;
        offer_frame(56'hAA010203040506, 7);
        rx_send(8'h61, 1'b0);
        repeat (50) tick();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_tx_ready", 32'(o_TX_READY), 32'd0);
        check("midrst_tx_byte", 32'(o_TX_BYTE), 32'd0);
        check("midrst_tx_byte_valid", 32'(o_TX_BYTE_VALID), 32'd0);
        check("midrst_rx_data", 32'(o_RX_DATA), 32'd0);
        tx_exp.delete();
        last_rx = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_ready_low", 32'(o_TX_READY), 32'd0);
        tick();
        check("midrst_ready_back", 32'(o_TX_READY), 32'd1);
        check("midrst_no_frame_done", 32'(frame_done_cnt), 32'(fd0));
        rx_cmd(8'h52, 8'h00, 1'b0, 16'h5200);
        send_frame(56'h611234_00000000, 3);

`ifdef UART_CTRL_CHKSUM_EN
        rx_cmd(8'h61, 8'h2A, 1'b1, 16'h612A);
        v0 = rx_valid_cnt;
        e0 = rx_err_cnt;
        rx_send(8'h61, 1'b0);
        rx_send(8'h2A, 1'b0);
        rx_send(8'h00, 1'b0);
        check("rx_bad_sum_err_now", 32'(o_RX_ERR), 32'd1);
        repeat (3) tick();
        check("rx_bad_sum_err", 32'(rx_err_cnt - e0), 32'd1);
        check("rx_bad_sum_no_valid", 32'(rx_valid_cnt - v0), 32'd0);
`endif

        repeat (5) tick();
        check("end_tx_queue", 32'(tx_exp.size()), 32'd0);
        check("end_rx_queue", 32'(rx_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
